// File: rtl/qspi_arb.sv
// Arbitrates the shared QSPI line-transfer engine between icache fills and
// dcache writeback+fill pairs, with beat-count checking and a grant timeout.
module qspi_arb #(
  parameter int          PA          = 22,
  parameter int          LINE_LENGTH = 4,
  parameter logic [6:0]  MEM_PREFIX  = 7'h7f,
  parameter int          TIMEOUT     = 255,
  localparam int         TW          = PA - $clog2(LINE_LENGTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [TW-1:0] i_tag,
  input  logic          d_req,
  input  logic          d_dirty,
  input  logic [TW-1:0] d_wtag,
  input  logic [TW-1:0] d_rtag,
  input  logic          q_wstrobe,
  input  logic          q_rstrobe,
  input  logic          q_done,
  output logic          q_req,
  output logic          q_i_d,
  output logic          q_write,
  output logic [TW-1:0] q_paddr,
  output logic          q_mem,
  output logic          i_wstrobe,
  output logic          d_wstrobe,
  output logic          d_rstrobe,
  output logic          i_done,
  output logic          d_done,
  output logic          i_fault,
  output logic          d_fault,
  output logic          err
);
  localparam int NB   = 2 * LINE_LENGTH;
  localparam int BW   = $clog2(NB + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, I_FILL, D_PUSH, D_PULL, GAP} state_t;

  state_t          state, state_nxt;
  logic            last_d;
  logic [BW-1:0]   bcnt, beats_now;
  logic [TO_W-1:0] tcnt;
  logic            grant, grant_nxt, beat, tmo, err_set;
  logic            i_done_nxt, d_done_nxt, i_fault_nxt, d_fault_nxt;
  logic [TW-1:0]   tag_nxt;
  logic            idd_nxt, wr_nxt;

  assign grant     = (state == I_FILL) || (state == D_PUSH) || (state == D_PULL);
  assign i_wstrobe = q_wstrobe & (state == I_FILL);
  assign d_rstrobe = q_rstrobe & (state == D_PUSH);
  assign d_wstrobe = q_wstrobe & (state == D_PULL);
  assign beat      = i_wstrobe | d_rstrobe | d_wstrobe;
  // beat on the q_done cycle itself still counts toward the line
  assign beats_now = (beat && bcnt != BW'(NB)) ? bcnt + BW'(1) : bcnt;
  assign tmo       = grant && !q_done && (tcnt == TO_W'(TIMEOUT - 1));
  assign err_set   = grant && q_done && (beats_now != BW'(NB));

  always_comb begin
    state_nxt   = state;
    i_done_nxt  = 1'b0;
    d_done_nxt  = 1'b0;
    i_fault_nxt = 1'b0;
    d_fault_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && (!d_req || last_d)) state_nxt = I_FILL;
        else if (d_req)                  state_nxt = d_dirty ? D_PUSH : D_PULL;
      end
      I_FILL: begin
        if (q_done)   begin state_nxt = GAP; i_done_nxt  = 1'b1; end
        else if (tmo) begin state_nxt = GAP; i_fault_nxt = 1'b1; end
      end
      D_PUSH: begin
        // push->pull is atomic; a timed-out push abandons the pull
        if (q_done)   state_nxt = D_PULL;
        else if (tmo) begin state_nxt = GAP; d_fault_nxt = 1'b1; end
      end
      D_PULL: begin
        if (q_done)   begin state_nxt = GAP; d_done_nxt  = 1'b1; end
        else if (tmo) begin state_nxt = GAP; d_fault_nxt = 1'b1; end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_nxt = (state_nxt == I_FILL) || (state_nxt == D_PUSH) ||
                     (state_nxt == D_PULL);

  // transfer attributes are latched only on grant entry so they stay stable
  always_comb begin
    tag_nxt = q_paddr;
    idd_nxt = q_i_d;
    wr_nxt  = q_write;
    if (state_nxt != state) begin
      case (state_nxt)
        I_FILL:  begin tag_nxt = i_tag;  idd_nxt = 1'b1; wr_nxt = 1'b0; end
        D_PUSH:  begin tag_nxt = d_wtag; idd_nxt = 1'b0; wr_nxt = 1'b1; end
        D_PULL:  begin tag_nxt = d_rtag; idd_nxt = 1'b0; wr_nxt = 1'b0; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      last_d  <= 1'b1;
      bcnt    <= '0;
      tcnt    <= '0;
      q_req   <= 1'b0;
      q_i_d   <= 1'b0;
      q_write <= 1'b0;
      q_paddr <= '0;
      q_mem   <= 1'b0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_fault <= 1'b0;
      d_fault <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      if (state == IDLE && state_nxt != IDLE) last_d <= (state_nxt != I_FILL);
      if (state_nxt != state) begin
        bcnt <= '0;
        tcnt <= '0;
      end else if (grant) begin
        bcnt <= beats_now;
        tcnt <= tcnt + TO_W'(1);
      end
      q_req   <= grant_nxt;
      q_i_d   <= idd_nxt;
      q_write <= wr_nxt;
      q_paddr <= tag_nxt;
      q_mem   <= (tag_nxt[TW-1 -: 7] == MEM_PREFIX);
      i_done  <= i_done_nxt;
      d_done  <= d_done_nxt;
      i_fault <= i_fault_nxt;
      d_fault <= d_fault_nxt;
      if (err_set) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_qspi_arb.sv
// Directed bench for qspi_arb: expected grants queued when requests are
// raised and popped when the arbiter opens the transfer.
module tb_qspi_arb;
  localparam int TW = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_dirty = 1'b0;
  logic [TW-1:0] i_tag = '0, d_wtag = '0, d_rtag = '0;
  logic          q_wstrobe = 1'b0, q_rstrobe = 1'b0, q_done = 1'b0;
  logic          q_req, q_i_d, q_write, q_mem;
  logic [TW-1:0] q_paddr;
  logic          i_wstrobe, d_wstrobe, d_rstrobe;
  logic          i_done, d_done, i_fault, d_fault, err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          i_d;
    logic          wr;
    logic          mem;
    logic [TW-1:0] tag;
  } exp_t;
  exp_t sb[$];

  qspi_arb #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_tag(i_tag),
    .d_req(d_req), .d_dirty(d_dirty), .d_wtag(d_wtag), .d_rtag(d_rtag),
    .q_wstrobe(q_wstrobe), .q_rstrobe(q_rstrobe), .q_done(q_done),
    .q_req(q_req), .q_i_d(q_i_d), .q_write(q_write), .q_paddr(q_paddr),
    .q_mem(q_mem),
    .i_wstrobe(i_wstrobe), .d_wstrobe(d_wstrobe), .d_rstrobe(d_rstrobe),
    .i_done(i_done), .d_done(d_done), .i_fault(i_fault), .d_fault(d_fault),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk20(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic i_d, input logic wr, input logic mem, input logic [TW-1:0] tag);
    exp_t e;
    e.i_d = i_d; e.wr = wr; e.mem = mem; e.tag = tag;
    sb.push_back(e);
  endtask

  // called in the first cycle of a grant
  task automatic pop_chk(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s: scoreboard empty got 0 entries expected 1", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk1({tag, "_q_req"}, q_req, 1'b1);
      chk1({tag, "_q_i_d"}, q_i_d, e.i_d);
      chk1({tag, "_q_write"}, q_write, e.wr);
      chk1({tag, "_q_mem"}, q_mem, e.mem);
      chk20({tag, "_q_paddr"}, q_paddr, e.tag);
    end
  endtask

  // n strobes (read side uses q_wstrobe), then a q_done pulse
  task automatic xfer(input int n, input logic use_w, input logic ei, input logic edw, input logic edr);
    for (int k = 0; k < n; k++) begin
      if (use_w) q_wstrobe = 1'b1; else q_rstrobe = 1'b1;
      #1;
      chk1("i_wstrobe", i_wstrobe, ei);
      chk1("d_wstrobe", d_wstrobe, edw);
      chk1("d_rstrobe", d_rstrobe, edr);
      step();
    end
    q_wstrobe = 1'b0;
    q_rstrobe = 1'b0;
    q_done = 1'b1;
    step();
    q_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    do_reset();
    chk1("rst_q_req", q_req, 1'b0);
    chk1("rst_q_mem", q_mem, 1'b0);
    chk20("rst_q_paddr", q_paddr, 20'h0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_i_done", i_done, 1'b0);

    // I-only fill
    i_req = 1'b1; i_tag = 20'h00010;
    push(1'b1, 1'b0, 1'b0, 20'h00010);
    #1 chk1("i_req_same_cycle", q_req, 1'b0);
    step();
    pop_chk("ifill");
    xfer(8, 1'b1, 1'b1, 1'b0, 1'b0);
    chk1("ifill_q_req_drop", q_req, 1'b0);
    chk1("ifill_i_done", i_done, 1'b1);
    chk1("ifill_err", err, 1'b0);
    i_req = 1'b0;
    step();
    chk1("ifill_i_done_1cyc", i_done, 1'b0);

    // q_done in IDLE is ignored
    q_done = 1'b1;
    step();
    q_done = 1'b0;
    chk1("idle_done_err", err, 1'b0);
    chk1("idle_done_q_req", q_req, 1'b0);
    chk1("idle_done_i_done", i_done, 1'b0);

    // dirty D miss: push then pull, one d_done
    d_req = 1'b1; d_dirty = 1'b1; d_wtag = 20'hFE001; d_rtag = 20'hFE002;
    push(1'b0, 1'b1, 1'b1, 20'hFE001);
    push(1'b0, 1'b0, 1'b1, 20'hFE002);
    step();
    pop_chk("dpush");
    xfer(8, 1'b0, 1'b0, 1'b0, 1'b1);
    chk1("dpush_no_done", d_done, 1'b0);
    pop_chk("dpull");
    xfer(8, 1'b1, 1'b0, 1'b1, 1'b0);
    chk1("dpull_d_done", d_done, 1'b1);
    chk1("dpull_q_req_drop", q_req, 1'b0);
    chk1("dpull_err", err, 1'b0);
    d_req = 1'b0; d_dirty = 1'b0;
    step();
    chk1("dpull_d_done_1cyc", d_done, 1'b0);

    // contention from reset: I, then D despite i_req, then I
    do_reset();
    i_req = 1'b1; i_tag = 20'h00123;
    d_req = 1'b1; d_rtag = 20'h00456;
    push(1'b1, 1'b0, 1'b0, 20'h00123);
    step();
    pop_chk("tie1_i");
    xfer(8, 1'b1, 1'b1, 1'b0, 1'b0);
    chk1("tie1_i_done", i_done, 1'b1);
    i_req = 1'b0;
    step();
    i_req = 1'b1; i_tag = 20'h00789;
    push(1'b0, 1'b0, 1'b0, 20'h00456);
    step();
    pop_chk("tie2_d");
    xfer(8, 1'b1, 1'b0, 1'b1, 1'b0);
    chk1("tie2_d_done", d_done, 1'b1);
    d_req = 1'b0;
    step();
    d_req = 1'b1; d_rtag = 20'h00aaa;
    push(1'b1, 1'b0, 1'b0, 20'h00789);
    step();
    pop_chk("tie3_i");

    // short transfer on this grant: err sets and sticks, i_done still pulses
    xfer(5, 1'b1, 1'b1, 1'b0, 1'b0);
    chk1("short_err", err, 1'b1);
    chk1("short_i_done", i_done, 1'b1);
    i_req = 1'b0; d_req = 1'b0;
    step();
    step();
    chk1("short_err_sticky", err, 1'b1);

    // timeout during push: fault after TIMEOUT grant cycles, pull abandoned
    do_reset();
    chk1("rst2_err", err, 1'b0);
    d_req = 1'b1; d_dirty = 1'b1; d_wtag = 20'hFE010; d_rtag = 20'hFE011;
    push(1'b0, 1'b1, 1'b1, 20'hFE010);
    step();
    pop_chk("tmo");
    for (int c = 2; c <= 16; c++) begin
      step();
      chk1("tmo_q_req_held", q_req, 1'b1);
      chk1("tmo_no_fault_yet", d_fault, 1'b0);
    end
    step();
    chk1("tmo_d_fault", d_fault, 1'b1);
    chk1("tmo_q_req_drop", q_req, 1'b0);
    chk1("tmo_no_d_done", d_done, 1'b0);
    d_req = 1'b0; d_dirty = 1'b0;
    step();
    chk1("tmo_fault_1cyc", d_fault, 1'b0);
    step();
    chk1("tmo_idle_q_req", q_req, 1'b0);

    // async reset mid push, then I wins the first tie
    d_req = 1'b1; d_dirty = 1'b1; d_wtag = 20'hFE020; d_rtag = 20'hFE021;
    push(1'b0, 1'b1, 1'b1, 20'hFE020);
    step();
    pop_chk("arst_push");
    q_rstrobe = 1'b1;
    #1 chk1("arst_pre_d_rstrobe", d_rstrobe, 1'b1);
    reset = 1'b0;
    #1;
    chk1("arst_q_req", q_req, 1'b0);
    chk1("arst_d_rstrobe", d_rstrobe, 1'b0);
    chk1("arst_q_write", q_write, 1'b0);
    q_rstrobe = 1'b0;
    step();
    reset = 1'b1;
    i_req = 1'b1; i_tag = 20'h00abc;
    push(1'b1, 1'b0, 1'b0, 20'h00abc);
    step();
    pop_chk("arst_tie_i");
    i_req = 1'b0; d_req = 1'b0;
    step();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qspi_arb.md
Name: qspi_arb

Overview:
- Sequences the single QSPI line-transfer engine between the instruction cache (line fill) and the data cache (dirty-line writeback then fill).
- Owns grant selection, tag/direction muxing and strobe routing.
- Checks nibble beat counts and enforces a transfer timeout.
- Sits between icache/dcache miss outputs and the qspi controller in the vc top level.

Parameters:
- PA, 22, physical address width
- LINE_LENGTH, 4, cache line bytes; tag is PA-1:$clog2(LINE_LENGTH); beats per line NB = 2*LINE_LENGTH nibbles
- MEM_PREFIX, 7'h7f, value of tag bits PA-1:PA-7 that selects PSRAM (q_mem=1), else flash
- TIMEOUT, 255, max cycles a grant may stay open without q_done

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  icache line fill request; held until i_done or i_fault
- i_tag  in  PA-$clog2(LINE_LENGTH)  icache miss tag
- d_req  in  1  dcache miss request; held until d_done or d_fault
- d_dirty  in  1  victim line must be written back first
- d_wtag  in  tag width  writeback (victim) tag
- d_rtag  in  tag width  fill tag
- q_wstrobe  in  1  qspi delivers a read nibble
- q_rstrobe  in  1  qspi consumes a write nibble
- q_done  in  1  qspi transfer complete (1-cycle pulse)
- q_req  out  1  transfer request to qspi
- q_i_d  out  1  1 = instruction-side transfer
- q_write  out  1  1 = writeback
- q_paddr  out  tag width  transfer tag
- q_mem  out  1  q_paddr[PA-1:PA-7]==MEM_PREFIX
- i_wstrobe, d_wstrobe, d_rstrobe  out  1  strobes gated by grant
- i_done, d_done  out  1  completion pulses
- i_fault, d_fault  out  1  timeout pulses
- err  out  1  sticky beat-count mismatch

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; q_paddr 0; beat and timeout counters 0; last_d=1 (I wins first tie); err=0.
- States: IDLE, I_FILL, D_PUSH, D_PULL, GAP.
- IDLE arbitration:
  - i_req only: go to I_FILL.
  - d_req only: go to D_PUSH if d_dirty, else D_PULL.
  - both: round-robin; the side not served last wins. last_d is updated on each grant.
- Outputs are registered. A request seen in IDLE at cycle N gives q_req=1 and valid q_paddr/q_i_d/q_write in cycle N+1.
- Grant-state outputs are held stable for the whole grant:
  - I_FILL: q_paddr=i_tag, q_i_d=1, q_write=0.
  - D_PUSH: q_paddr=d_wtag, q_write=1.
  - D_PULL: q_paddr=d_rtag, q_write=0.
- Strobe routing: i_wstrobe=q_wstrobe&I_FILL; d_rstrobe=q_rstrobe&D_PUSH; d_wstrobe=q_wstrobe&D_PULL. All are combinational, zero latency. Strobes in any other state are dropped.
- Beat counter: cleared on grant entry; increments on each routed strobe; saturates at NB.
- On q_done the beat count must equal NB, otherwise err is set (sticky until reset). Completion proceeds either way.
- Completion, on the q_done cycle:
  - q_req drops next cycle.
  - I_FILL: i_done pulses 1 cycle; next state GAP.
  - D_PUSH: no done pulse; next state D_PULL directly, counters cleared, q_req stays 1 with a new tag. The push→pull pair is atomic and I cannot intervene.
  - D_PULL: d_done pulses; next state GAP.
- GAP: one idle cycle so the requester can drop its req; then IDLE.
- Timeout: a counter runs in grant states. On reaching TIMEOUT without q_done:
  - pulse i_fault or d_fault;
  - q_req=0; next state GAP;
  - a pending pull after a timed-out push is abandoned.
- A q_done arriving in IDLE or GAP is ignored.
- Requester drops req mid-grant: the transfer completes regardless and the done pulse is still issued.
- Simultaneous q_done and timeout in the same cycle: q_done wins.

Test Plan:
- I-only fill: i_req=1, i_tag=20'h00010, 8 q_wstrobes, q_done → q_req rises 1 cycle after i_req; q_i_d=1, q_mem=0, 8 i_wstrobes, i_done 1 pulse, err=0.
- Dirty D miss: d_dirty=1, d_wtag=20'hFE001, d_rtag=20'hFE002 → D_PUSH (q_write=1, q_mem=1, 8 d_rstrobes), q_done, then the next cycle D_PULL with q_paddr=FE002; a single d_done only after the second q_done.
- Contention: i_req and d_req together from reset → I granted first. After GAP, D is granted even though i_req is reasserted. Next tie → I.
- Short transfer: 5 strobes then q_done → err=1 and held; i_done still pulses.
- Timeout with TIMEOUT=16: grant and never q_done → d_fault pulses on cycle 16 of the grant, q_req=0, IDLE reached after GAP.
- Async reset mid D_PUSH: reset=0 → q_req and all strobe outputs 0 immediately. After release, a new i_req is served first (last_d=1).
